// File: rtl/shift_reg_universal_param.sv
`default_nettype none
// ============================================================================
// shift_reg_universal_param : universal shift register with WIDTH-shift burst FSM
// Revision 1.0
// ============================================================================
module shift_reg_universal_param #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic                         start,
  input  logic                         si_r,
  input  logic                         si_l,
  input  logic [WIDTH-1:0]             pi,
  output logic [WIDTH-1:0]             po,
  output logic                         so_r,
  output logic                         so_l,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int c_CW = $clog2(WIDTH + 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  localparam logic [2:0] c_OP_HOLD = 3'b000;
  localparam logic [2:0] c_OP_SHR  = 3'b001;
  localparam logic [2:0] c_OP_SHL  = 3'b010;
  localparam logic [2:0] c_OP_LOAD = 3'b011;
  localparam logic [2:0] c_OP_ROR  = 3'b100;
  localparam logic [2:0] c_OP_ROL  = 3'b101;
  localparam logic [2:0] c_OP_ASR  = 3'b110;

  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_po;
  logic [c_CW-1:0]  r_count;
  logic             w_burst_ok;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_manual_po;
  logic [WIDTH-1:0] w_burst_po;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] pin
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      c_OP_SHR:  res = {sr, cur[WIDTH-1:1]};
      c_OP_SHL:  res = {cur[WIDTH-2:0], sl};
      c_OP_LOAD: res = pin;
      c_OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      c_OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      c_OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   res = cur;
    endcase
    return res;
  endfunction

  // Only true shift/rotate ops can run as a burst; hold, load and reserved cannot.
  always_comb begin
    w_burst_ok = 1'b0;
    case (mode)
      c_OP_SHR, c_OP_SHL, c_OP_ROR, c_OP_ROL, c_OP_ASR: w_burst_ok = 1'b1;
      default:                                          w_burst_ok = 1'b0;
    endcase
  end

  assign w_accept    = (r_state == c_S_IDLE) && start && w_burst_ok;
  assign w_last      = (r_count == c_LAST);
  assign w_manual_po = apply_op(mode, r_po, si_r, si_l, pi);
  assign w_burst_po  = apply_op(r_op, r_po, si_r, si_l, pi);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_accept) w_state_nxt = c_S_RUN;
      c_S_RUN:  if (w_last)   w_state_nxt = c_S_DONE;
      c_S_DONE: w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_S_RUN:  busy = 1'b1;
      c_S_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: burst activity outranks start acceptance, which outranks en/mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_po    <= RST_VAL;
      r_count <= '0;
      r_op    <= c_OP_HOLD;
    end else begin
      case (r_state)
        c_S_RUN: begin
          r_po    <= w_burst_po;
          r_count <= r_count + c_ONE;
        end
        c_S_IDLE: begin
          if (w_accept) begin
            r_op    <= mode;
            r_count <= '0;
          end else if (en) begin
            r_po <= w_manual_po;
          end
        end
        default: begin
          r_po <= r_po;
        end
      endcase
    end
  end

  assign po    = r_po;
  assign so_r  = r_po[0];
  assign so_l  = r_po[WIDTH-1];
  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal_param.sv
`default_nettype none
// ============================================================================
// tb_shift_reg_universal_param : directed + random checks against a burst model
// Revision 1.0
// ============================================================================
module tb_shift_reg_universal_param;

  logic       clk = 1'b0;
  logic       rst, en, start, si_r, si_l;
  logic [2:0] mode;
  logic [7:0] pi;
  logic [7:0] po;
  logic       so_r, so_l, busy, done;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining-shift counter instead of explicit states
  logic [7:0] m_po;
  logic [2:0] m_op;
  int         m_count;
  int         m_left;
  bit         m_done;

  shift_reg_universal_param #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
    .si_r(si_r), .si_l(si_l), .pi(pi), .po(po), .so_r(so_r), .so_l(so_l),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] v,
                                        input logic sr, input logic sl, input logic [7:0] p);
    int x;
    x = int'(v);
    case (op)
      3'd1: x = (x / 2) + (sr ? 128 : 0);
      3'd2: x = ((x * 2) % 256) + (sl ? 1 : 0);
      3'd3: x = int'(p);
      3'd4: x = (x / 2) + ((x % 2) * 128);
      3'd5: x = ((x * 2) % 256) + (x / 128);
      3'd6: x = (x / 2) + ((x >= 128) ? 128 : 0);
      default: x = int'(v);
    endcase
    return x[7:0];
  endfunction

  function automatic bit is_burst(input logic [2:0] md);
    return (md != 3'd0) && (md != 3'd3) && (md != 3'd7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] n_po;
    logic [2:0] n_op;
    int n_count, n_left;
    bit n_done;
    n_po = m_po; n_op = m_op; n_count = m_count; n_left = m_left; n_done = 1'b0;
    if (rst) begin
      n_po = 8'h00; n_op = 3'd0; n_count = 0; n_left = 0;
    end else if (m_left > 0) begin
      n_po = ref_op(m_op, m_po, si_r, si_l, pi);
      n_count = m_count + 1;
      n_left = m_left - 1;
      n_done = (n_left == 0);
    end else if (m_done) begin
      n_done = 1'b0;
    end else if (start && is_burst(mode)) begin
      n_op = mode; n_count = 0; n_left = 8;
    end else if (en) begin
      n_po = ref_op(mode, m_po, si_r, si_l, pi);
    end
    @(posedge clk);
    #1;
    m_po = n_po; m_op = n_op; m_count = n_count; m_left = n_left; m_done = n_done;
    chk("po", 32'(po), 32'(m_po));
    chk("so_r", 32'(so_r), 32'(m_po[0]));
    chk("so_l", 32'(so_l), 32'(m_po[7]));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("count", 32'(count), 32'(m_count));
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] md, input logic s,
                       input logic sr, input logic sl, input logic [7:0] p);
    rst = r; en = e; mode = md; start = s; si_r = sr; si_l = sl; pi = p;
  endtask

  initial begin
    int  bcnt;
    bit  seen;
    logic [7:0] snap;
    m_po = '0; m_op = '0; m_count = 0; m_left = 0; m_done = 1'b0;
    drive(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'hFF);
    #2;
    tick();
    // Reset dominance
    chk("rst_po", 32'(po), 32'h00);
    chk("rst_so", 32'({so_l, so_r}), 32'h0);
    chk("rst_busy_done", 32'({busy, done}), 32'h0);
    chk("rst_count", 32'(count), 32'h0);

    // Load and shift right
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'hA5); tick();
    chk("ld_A5_sor", 32'(so_r), 32'h1);
    drive(1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    chk("shr_D2", 32'(po), 32'hD2);
    chk("shr_sor", 32'(so_r), 32'h0);

    // Rotate left and arithmetic shift right
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'h81); tick();
    drive(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    chk("rol_03", 32'(po), 32'h03);
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'h80); tick();
    drive(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    chk("asr_C0", 32'(po), 32'hC0);

    // Burst shift left with mid-burst start and en toggling
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'hB4); tick();
    drive(1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk("burst_accept_po", 32'(po), 32'hB4);
    start = 1'b0;
    bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) bcnt++;
      en = ~en;
      start = (i == 3);
      mode = (i == 3) ? 3'b001 : 3'b011;
      tick();
      if (done) seen = 1'b1;
    end
    chk("burst_done_seen", 32'(seen), 32'h1);
    chk("burst_busy_cycles", 32'(bcnt), 32'd8);
    chk("burst_po", 32'(po), 32'h00);
    chk("burst_count", 32'(count), 32'd8);
    drive(1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk("done_to_idle", 32'({busy, done}), 32'h0);
    chk("count_hold", 32'(count), 32'd8);

    // Reset mid-burst
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'hA5); tick();
    drive(1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_count3", 32'(count), 32'd3);
    rst = 1'b1; tick();
    chk("mid_rst_po", 32'(po), 32'h00);
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_rst_no_done", 32'(done), 32'h0);
    end

    // Holds and ignored starts
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'h5C); tick();
    snap = po;
    drive(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 8'h00); tick();
    chk("en0_hold", 32'(po), 32'(snap));
    drive(1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 8'h00); tick();
    chk("mode7_hold", 32'(po), 32'(snap));
    drive(1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 8'h3E); tick();
    chk("start_load_po", 32'(po), 32'h3E);
    chk("start_load_busy", 32'(busy), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom), 3'($urandom),
            ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_reg_universal_param.md
SHIFT_REG_UNIVERSAL_PARAM -- requirements
Module: shift_reg_universal_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits, legal range 2..32.
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}: value loaded into po on reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset, as follows.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high, sampled only on the rising edge of clk.
REQ-006 en  input  1  manual-operation enable; ignored while a burst is running.
REQ-007 mode  input  3  operation select (encoding in REQ-013).
REQ-008 start  input  1  burst request; sampled only in IDLE.
REQ-009 si_r  input  1  serial input entering the MSB on right shifts.
REQ-010 si_l  input  1  serial input entering the LSB on left shifts.
REQ-011 pi  input  WIDTH  parallel load data.
REQ-012 Outputs: po (WIDTH, register contents); so_r (1, =po[0], combinational); so_l (1, =po[WIDTH-1], combinational); busy (1); done (1); count ($clog2(WIDTH+1), burst shifts completed).

Function
REQ-013 mode encoding SHALL be: 000 hold; 001 shift right {si_r,po[W-1:1]}; 010 shift left {po[W-2:0],si_l}; 011 parallel load pi; 100 rotate right {po[0],po[W-1:1]}; 101 rotate left {po[W-2:0],po[W-1]}; 110 arithmetic shift right {po[W-1],po[W-1:1]}; 111 reserved, behaves as hold.
REQ-014 Controller SHALL be an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE with en=1 and start=0, po SHALL update per mode on each edge, with one-cycle latency.
REQ-016 In IDLE with en=0 and start=0, po SHALL hold.
REQ-017 Start acceptance: in IDLE, start=1 with mode in {001,010,100,101,110} SHALL be accepted, whatever the value of en. On that edge: mode is captured, count <= 0, state <= RUN, po holds.
REQ-018 Start with mode in {000,011,111} SHALL be ignored; en/mode then act as in REQ-015/016.
REQ-019 In RUN, every edge SHALL apply the captured op and increment count, ignoring en, mode and start.
REQ-020 Serial inputs SHALL be sampled live on each RUN edge.
REQ-021 The RUN edge on which count reaches WIDTH SHALL move the FSM to DONE, so a burst performs exactly WIDTH shifts.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 done SHALL be 1 exactly while in DONE (a one-cycle pulse); po holds in DONE.
REQ-024 DONE SHALL move to IDLE on the next edge unconditionally; start asserted in DONE is ignored.
REQ-025 count SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-026 Priority SHALL be: rst > RUN/DONE burst activity > start acceptance > en/mode.

Reset
REQ-027 When rst=1 at an edge, next-state values SHALL be: po=RST_VAL, state=IDLE, count=0, busy=0, done=0, captured op=hold, regardless of all other inputs.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-029 so_r and so_l SHALL follow the reset value of po.
REQ-030 Before the first reset, output values are undefined; the bench SHALL apply reset first.

Verification (WIDTH=8, RST_VAL=0)
REQ-031 Reset dominance: rst=1 with en=1, mode=011, pi=FF -> po=00, so_r=0, so_l=0, busy=0, done=0, count=0.
REQ-032 Load and shift: load A5, then mode=001 with si_r=1 -> po=D2; so_r is 1 before the shift and 0 after it.
REQ-033 Rotate and arithmetic shift: load 81 then mode=101 -> po=03; load 80 then mode=110 -> po=C0.
REQ-034 Burst shift: load B4, then start with mode=010 and si_l=0.
- busy=1 for exactly 8 cycles, then done=1 for one cycle, then IDLE.
- Final po=00 and count=8.
- A start pulse mid-burst and en toggling during the burst have no effect.
REQ-035 Reset mid-burst: assert rst after the 3rd shift of a burst -> next edge gives po=00, count=0, busy=0, and done never pulses.
REQ-036 Holds and ignored starts:
- en=0 with mode=001 -> po unchanged.
- mode=111 with en=1 -> po unchanged.
- start with mode=011 -> burst not started; with en=1, pi is loaded.
